clock_mode_controller: RTL

- Front-panel sequencer for the digital clock. It takes the raw SW_MODE, SW_SEL and SW_INC buttons, then synchronizes, debounces and edge-detects them.
- Runs the mode FSM: NORMAL, TIMESET, ALARMSET, STOPWATCH.
- Issues field-select, increment, blink and stopwatch-control strobes to the time, alarm and stopwatch counter datapaths.
- Sits between the button pins and the counter banks; it owns all user-driven sequencing.

---
 rtl/clock_mode_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/clock_mode_controller.sv
// clock_mode_controller
//   Front-panel sequencer for the digital clock. Conditions the three raw
//   buttons (2-FF sync, debounce, press detect), runs the mode FSM
//   NORMAL -> TIMESET -> ALARMSET -> STOPWATCH and drives the strobes for the
//   time, alarm and stopwatch datapaths.
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   SW_MODE/SEL/INC raw active-high buttons (asynchronous)
//   TIMESET_RUN, ALARMSET_RUN, STOPWATCH_RUN  one-hot mode flags (none = NORMAL)
//   FIELD          edited field (2=hour, 1=min, 0=sec)
//   TS_INC, AL_INC one-cycle increment strobes, bit index = FIELD
//   SWATCH_EN      stopwatch counting enable (level)
//   SWATCH_CLR     one-cycle stopwatch clear strobe
//   BLINK          blink for the edited field
module clock_mode_controller #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned BLINK_HALF = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW_MODE,
  input  logic       SW_SEL,
  input  logic       SW_INC,
  output logic       TIMESET_RUN,
  output logic       ALARMSET_RUN,
  output logic       STOPWATCH_RUN,
  output logic [1:0] FIELD,
  output logic [2:0] TS_INC,
  output logic [2:0] AL_INC,
  output logic       SWATCH_EN,
  output logic       SWATCH_CLR,
  output logic       BLINK
);

  typedef enum logic [1:0] {NORMAL, TIMESET, ALARMSET, STOPWATCH} mode_e;

  localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned IW   = $clog2(TIMEOUT + 1);
  localparam int unsigned BW   = $clog2(BLINK_HALF + 1);
  localparam int unsigned RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  // Button index: 0 = MODE, 1 = SEL, 2 = INC
  logic [2:0]    sync1_q, sync2_q, lvl_q;
  logic [DW-1:0] deb_cnt_q [3];
  logic [2:0]    flip, rise;

  mode_e         mode_q, mode_d;
  logic [IW-1:0] idle_q;
  logic [BW-1:0] blink_cnt_q;
  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_en_q, rpt_per_q;

  logic set_mode, set_next, rpt_fire, timeout;
  logic ev_mode, ev_sel, ev_inc, any_ev, blink_force;

  // The level flips on the edge that would register the DEB_CYCLES-th
  // differing sample; rise is presented combinationally so the mode logic
  // reacts on that same edge (raw edge -> strobe in DEB_CYCLES+2 edges).
  always_comb begin
    for (int unsigned b = 0; b < 3; b++) begin
      flip[b] = (sync2_q[b] != lvl_q[b]) && (deb_cnt_q[b] == DW'(DEB_CYCLES - 1));
      rise[b] = flip[b] & sync2_q[b];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      for (int unsigned b = 0; b < 3; b++) deb_cnt_q[b] <= '0;
    end else begin
      sync1_q <= {SW_INC, SW_SEL, SW_MODE};
      sync2_q <= sync1_q;
      for (int unsigned b = 0; b < 3; b++) begin
        if (sync2_q[b] == lvl_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (flip[b]) begin
          lvl_q[b]     <= sync2_q[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    set_mode = (mode_q == TIMESET) || (mode_q == ALARMSET);
    rpt_fire = rpt_en_q && lvl_q[2] && set_mode &&
               (rpt_cnt_q == (rpt_per_q ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1)));
    timeout  = set_mode && (idle_q == IW'(TIMEOUT));
    // Priority: timeout > MODE > SEL > INC (press or repeat)
    ev_mode  = !timeout && rise[0];
    ev_sel   = !timeout && !rise[0] && rise[1];
    ev_inc   = !timeout && !rise[0] && !rise[1] && (rise[2] || rpt_fire);
    any_ev   = (|rise) || rpt_fire;

    mode_d = mode_q;
    if (timeout) begin
      mode_d = NORMAL;
    end else if (ev_mode) begin
      case (mode_q)
        NORMAL:   mode_d = TIMESET;
        TIMESET:  mode_d = ALARMSET;
        ALARMSET: mode_d = STOPWATCH;
        default:  mode_d = NORMAL;
      endcase
    end
    set_next    = (mode_d == TIMESET) || (mode_d == ALARMSET);
    blink_force = (ev_mode && set_next) || (set_mode && (ev_sel || ev_inc));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q        <= NORMAL;
      TIMESET_RUN   <= 1'b0;
      ALARMSET_RUN  <= 1'b0;
      STOPWATCH_RUN <= 1'b0;
      FIELD         <= 2'd2;
      TS_INC        <= '0;
      AL_INC        <= '0;
      SWATCH_EN     <= 1'b0;
      SWATCH_CLR    <= 1'b0;
      BLINK         <= 1'b0;
      idle_q        <= '0;
      blink_cnt_q   <= '0;
      rpt_cnt_q     <= '0;
      rpt_en_q      <= 1'b0;
      rpt_per_q     <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      TIMESET_RUN   <= (mode_d == TIMESET);
      ALARMSET_RUN  <= (mode_d == ALARMSET);
      STOPWATCH_RUN <= (mode_d == STOPWATCH);
      TS_INC        <= '0;
      AL_INC        <= '0;
      SWATCH_CLR    <= 1'b0;

      if (any_ev || timeout || !set_mode) idle_q <= '0;
      else                                idle_q <= idle_q + IW'(1);

      if (ev_mode) begin
        if (set_next) FIELD <= 2'd2;
      end else if (ev_sel) begin
        case (mode_q)
          TIMESET:   FIELD     <= (FIELD == 2'd0) ? 2'd2 : FIELD - 2'd1;
          ALARMSET:  FIELD     <= (FIELD == 2'd2) ? 2'd1 : 2'd2;
          STOPWATCH: SWATCH_EN <= !SWATCH_EN;
          default:   ;
        endcase
      end else if (ev_inc) begin
        case (mode_q)
          TIMESET:   TS_INC     <= 3'b001 << FIELD;
          ALARMSET:  AL_INC     <= 3'b001 << FIELD;
          STOPWATCH: SWATCH_CLR <= !SWATCH_EN;
          default:   ;
        endcase
      end

      if (!set_next) begin
        BLINK       <= 1'b0;
        blink_cnt_q <= '0;
      end else if (blink_force) begin
        BLINK       <= 1'b1;
        blink_cnt_q <= '0;
      end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        BLINK       <= !BLINK;
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end

      // Repeat is armed only by an accepted INC press; a held button never
      // re-arms after a mode change because that needs a fresh rising edge.
      if (timeout || ev_mode) begin
        rpt_en_q <= 1'b0;
      end else if (ev_inc && rise[2] && set_mode) begin
        rpt_en_q  <= 1'b1;
        rpt_per_q <= 1'b0;
        rpt_cnt_q <= '0;
      end else if (!lvl_q[2]) begin
        rpt_en_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_per_q <= 1'b1;
        rpt_cnt_q <= '0;
      end else if (rpt_en_q) begin
        rpt_cnt_q <= rpt_cnt_q + RW'(1);
      end
    end
  end

endmodule
